axis_stim_gen: RTL and testbench

Parametrised AXI4-Stream stimulus source for the GCC-PHAT pipeline. It drives the `gcc` data input with framed multichannel samples in place of a constant all-ones word. It generates constant, per-channel-lagged ramp, or LFSR patterns, with programmable valid throttling and `tlast` framing. It also counts completed frames, so that delay estimates from `gcc` can be checked against a known inter-channel lag.

---
 rtl/axis_stim_gen.sv | 189 ++++++++++++++++++
 tb/tb_axis_stim_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axis_stim_gen.sv
// rtl/axis_stim_gen.sv - AXI4-Stream framed stimulus source (constant, lagged ramp, LFSR)
// Beats are fully registered; throttle gaps and config changes apply at beat/frame boundaries.
module axis_stim_gen #(
  parameter int          DATA_WIDTH = 128,
  parameter int          CHANNELS   = 4,
  parameter int          FRAME_LEN  = 1024,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [15:0]           lag,
  input  logic [3:0]            throttle,
  output logic [DATA_WIDTH-1:0] M_AXIS_DATA_tdata,
  output logic                  M_AXIS_DATA_tvalid,
  input  logic                  M_AXIS_DATA_tready,
  output logic                  M_AXIS_DATA_tlast,
  output logic [15:0]           frames_sent,
  output logic                  busy
);

  localparam int LW = DATA_WIDTH / CHANNELS;
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = (LW > 48) ? LW : 48;
  localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state, state_nx;
  logic                    tvalid_q, tvalid_nx;
  logic                    tlast_q, tlast_nx;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_nx;
  logic [15:0]             frame_count, frames_nx;
  logic                    busy_q;
  logic [31:0]             sample_idx, sample_idx_nx;
  logic [BW-1:0]           beat_cnt, beat_nx;
  logic [31:0]             lfsr, lfsr_nx;
  logic [3:0]              thr_cnt, thr_nx;
  logic [1:0]              cfg_mode, mode_nx;
  logic [15:0]             cfg_lag, lag_nx;
  logic [3:0]              cfg_thr, thr_cfg_nx;
  logic                    hs, last_hs;

  function automatic logic [31:0] lfsr_step(input logic [31:0] lf);
    return (lf >> 1) ^ (lf[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Lane k of mode 1 is lane 0 delayed by k*lag samples, modulo 2^LW.
  function automatic logic [DATA_WIDTH-1:0] make_data(input logic [1:0] m, input logic [15:0] lg,
                                                      input logic [31:0] idx, input logic [31:0] lf);
    logic [DATA_WIDTH-1:0] w;
    logic [LW-1:0]         lane;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (m)
        2'd1:    lane = LW'(AW'(idx) - AW'(k) * AW'(lg));
        2'd2:    lane = LW'(lf) ^ LW'(k);
        default: lane = '1;
      endcase
      w[k*LW +: LW] = lane;
    end
    return w;
  endfunction

  assign hs      = tvalid_q & M_AXIS_DATA_tready;
  assign last_hs = hs & tlast_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      frame_count <= 16'd0;
      busy_q      <= 1'b0;
      sample_idx  <= 32'd0;
      beat_cnt    <= '0;
      lfsr        <= LFSR_SEED;
      thr_cnt     <= 4'd0;
      cfg_mode    <= 2'd0;
      cfg_lag     <= 16'd0;
      cfg_thr     <= 4'd0;
    end else begin
      state       <= state_nx;
      tvalid_q    <= tvalid_nx;
      tlast_q     <= tlast_nx;
      tdata_q     <= tdata_nx;
      frame_count <= frames_nx;
      busy_q      <= (state_nx != S_IDLE);
      sample_idx  <= sample_idx_nx;
      beat_cnt    <= beat_nx;
      lfsr        <= lfsr_nx;
      thr_cnt     <= thr_nx;
      cfg_mode    <= mode_nx;
      cfg_lag     <= lag_nx;
      cfg_thr     <= thr_cfg_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    tvalid_nx     = tvalid_q;
    tlast_nx      = tlast_q;
    tdata_nx      = tdata_q;
    frames_nx     = frame_count;
    sample_idx_nx = sample_idx;
    beat_nx       = beat_cnt;
    lfsr_nx       = lfsr;
    thr_nx        = thr_cnt;
    mode_nx       = cfg_mode;
    lag_nx        = cfg_lag;
    thr_cfg_nx    = cfg_thr;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx      = S_RUN;
          mode_nx       = mode;
          lag_nx        = lag;
          thr_cfg_nx    = throttle;
          sample_idx_nx = 32'd0;
          lfsr_nx       = LFSR_SEED;
          beat_nx       = '0;
          thr_nx        = 4'd0;
          tvalid_nx     = 1'b1;
          tlast_nx      = 1'b0;
          tdata_nx      = make_data(mode, lag, 32'd0, LFSR_SEED);
        end
      end
      default: begin
        if (hs) begin
          sample_idx_nx = sample_idx + 32'd1;
          lfsr_nx       = lfsr_step(lfsr);
          beat_nx       = last_hs ? '0 : beat_cnt + BW'(1);
          if (last_hs) begin
            frames_nx  = frame_count + 16'd1;
            mode_nx    = mode;
            lag_nx     = lag;
            thr_cfg_nx = throttle;
          end
          if (last_hs && (state == S_DRAIN || !enable)) begin
            state_nx  = S_IDLE;
            tvalid_nx = 1'b0;
            tlast_nx  = 1'b0;
            thr_nx    = 4'd0;
          end else begin
            if (state == S_RUN && !enable) state_nx = S_DRAIN;
            // The gap after a beat belongs to that beat's frame, so it uses the old throttle.
            if (cfg_thr != 4'd0) begin
              tvalid_nx = 1'b0;
              tlast_nx  = 1'b0;
              thr_nx    = cfg_thr;
            end else begin
              tvalid_nx = 1'b1;
              tdata_nx  = make_data(mode_nx, lag_nx, sample_idx_nx, lfsr_nx);
              tlast_nx  = (beat_nx == LAST_BEAT);
            end
          end
        end else if (!tvalid_q) begin
          if (state == S_RUN && !enable && beat_cnt == '0) begin
            state_nx = S_IDLE;
            thr_nx   = 4'd0;
          end else begin
            if (state == S_RUN && !enable) state_nx = S_DRAIN;
            if (thr_cnt <= 4'd1) begin
              tvalid_nx = 1'b1;
              tdata_nx  = make_data(cfg_mode, cfg_lag, sample_idx, lfsr);
              tlast_nx  = (beat_cnt == LAST_BEAT);
              thr_nx    = 4'd0;
            end else begin
              thr_nx = thr_cnt - 4'd1;
            end
          end
        end else if (state == S_RUN && !enable) begin
          state_nx = S_DRAIN;
        end
      end
    endcase
  end

  assign M_AXIS_DATA_tdata  = tdata_q;
  assign M_AXIS_DATA_tvalid = tvalid_q;
  assign M_AXIS_DATA_tlast  = tlast_q;
  assign frames_sent        = frame_count;
  assign busy               = busy_q;

endmodule

// File: tb/tb_axis_stim_gen.sv
// tb/tb_axis_stim_gen.sv - directed self-checking bench for axis_stim_gen
// FRAME_LEN=8, 4 lanes of 32 bits; outputs sampled 1ns after each rising edge.
module tb_axis_stim_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   mode;
  logic [15:0]  lag;
  logic [3:0]   throttle;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [15:0]  frames_sent;
  logic         busy;
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  lfsr_exp [5];

  axis_stim_gen #(.DATA_WIDTH(128), .CHANNELS(4), .FRAME_LEN(8), .LFSR_SEED(32'hACE1_2468)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .lag(lag), .throttle(throttle),
    .M_AXIS_DATA_tdata(tdata), .M_AXIS_DATA_tvalid(tvalid), .M_AXIS_DATA_tready(tready),
    .M_AXIS_DATA_tlast(tlast), .frames_sent(frames_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_wait", 128'(busy | tvalid), 128'(0));
  endtask

  function automatic logic [127:0] ramp(input logic [31:0] idx, input logic [15:0] lg);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = idx - 32'(k) * 32'(lg);
    return w;
  endfunction

  function automatic logic [127:0] lfsr_word(input logic [31:0] l);
    return {l ^ 32'd3, l ^ 32'd2, l ^ 32'd1, l};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    lfsr_exp = '{32'hACE12468, 32'h56709234, 32'h2B38491A, 32'h159C248D, 32'h8AEE1245};
    rst = 1'b1; enable = 1'b0; mode = 2'd0; lag = 16'd0; throttle = 4'd0; tready = 1'b1;
    tick();
    tick();
    chk("rst_tvalid", 128'(tvalid), 128'(0));
    chk("rst_tlast", 128'(tlast), 128'(0));
    chk("rst_tdata", tdata, 128'(0));
    chk("rst_frames", 128'(frames_sent), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_tvalid", 128'(tvalid), 128'(0));

    // constant pattern, full throughput, enable dropped mid frame 3
    enable = 1'b1;
    tick();
    for (int b = 0; b < 24; b++) begin
      chk("c_tvalid", 128'(tvalid), 128'(1));
      chk("c_tdata", tdata, {128{1'b1}});
      chk("c_tlast", 128'(tlast), 128'(b % 8 == 7));
      chk("c_busy", 128'(busy), 128'(1));
      if (b == 8) chk("c_frames1", 128'(frames_sent), 128'(1));
      if (b == 19) enable = 1'b0;
      tick();
    end
    chk("c_end_tvalid", 128'(tvalid), 128'(0));
    chk("c_end_busy", 128'(busy), 128'(0));
    chk("c_frames", 128'(frames_sent), 128'(3));

    // lagged ramp, lag 5
    mode = 2'd1; lag = 16'd5; enable = 1'b1;
    tick();
    chk("ramp_b0", tdata, 128'hFFFFFFF1_FFFFFFF6_FFFFFFFB_00000000);
    repeat (10) tick();
    chk("ramp_b10", tdata, 128'hFFFFFFFB_00000000_00000005_0000000A);
    enable = 1'b0;
    wait_idle(40);
    chk("ramp_frames", 128'(frames_sent), 128'(5));

    // backpressure: tready 1,0,0,1
    lag = 16'd3; enable = 1'b1;
    tick();
    begin
      logic [31:0] exp_idx;
      exp_idx = 32'd0;
      for (int c = 0; c < 24; c++) begin
        chk("bp_tvalid", 128'(tvalid), 128'(1));
        chk("bp_tdata", tdata, ramp(exp_idx, 16'd3));
        chk("bp_tlast", 128'(tlast), 128'(exp_idx % 8 == 7));
        tready = (c % 4 == 0) || (c % 4 == 3);
        if (tready) exp_idx++;
        tick();
      end
    end
    tready = 1'b1; enable = 1'b0;
    wait_idle(40);
    chk("bp_frames", 128'(frames_sent), 128'(7));

    // throttle 3, changed to 0 during frame 1
    mode = 2'd0; lag = 16'd0; throttle = 4'd3; enable = 1'b1;
    tick();
    for (int c = 0; c < 72; c++) begin
      chk("thr_tvalid", 128'(tvalid), 128'((c < 64) ? (c % 4 == 0) : 1'b1));
      chk("thr_tlast", 128'(tlast), 128'((c == 28) || (c == 60) || (c == 71)));
      if (tvalid) chk("thr_tdata", tdata, {128{1'b1}});
      if (c == 34) throttle = 4'd0;
      if (c == 71) enable = 1'b0;
      tick();
    end
    chk("thr_end_tvalid", 128'(tvalid), 128'(0));
    chk("thr_end_busy", 128'(busy), 128'(0));
    chk("thr_frames", 128'(frames_sent), 128'(10));

    // LFSR pattern
    mode = 2'd2; enable = 1'b1;
    tick();
    for (int b = 0; b < 5; b++) begin
      chk("lfsr_tdata", tdata, lfsr_word(lfsr_exp[b]));
      tick();
    end
    enable = 1'b0;
    wait_idle(40);
    chk("lfsr_frames", 128'(frames_sent), 128'(11));

    // async reset at beat 4
    mode = 2'd1; lag = 16'd2; enable = 1'b1;
    tick();
    repeat (4) tick();
    chk("ar_b4", tdata, ramp(32'd4, 16'd2));
    chk("ar_frames_pre", 128'(frames_sent), 128'(11));
    #2 rst = 1'b1;
    #1;
    chk("ar_tvalid", 128'(tvalid), 128'(0));
    chk("ar_tlast", 128'(tlast), 128'(0));
    chk("ar_busy", 128'(busy), 128'(0));
    chk("ar_tdata", tdata, 128'(0));
    chk("ar_frames", 128'(frames_sent), 128'(0));
    #2 rst = 1'b0;
    tick();
    chk("ar_restart_tvalid", 128'(tvalid), 128'(1));
    chk("ar_restart_tdata", tdata, ramp(32'd0, 16'd2));
    chk("ar_restart_tlast", 128'(tlast), 128'(0));
    enable = 1'b0;
    wait_idle(40);
    chk("ar_frames_post", 128'(frames_sent), 128'(1));

    // frame counter wrap from a preloaded 0xFFFF
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    tick();
    chk("wrap_pre", 128'(frames_sent), 128'(16'hFFFF));
    mode = 2'd0; enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle(40);
    chk("wrap_post", 128'(frames_sent), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
